// File: rtl/cmpgt_argmax.sv
// Streaming argmax stage: reduces a valid/ready frame of samples to {max, index, overflow}.
// Includes the cmpgt strict greater-than comparator that it instantiates.

module cmpgt #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             gt
);

    always_comb begin
        gt = is_signed ? ($signed(a) > $signed(b)) : (a > b);
    end

endmodule

// Handshake: a beat moves on a rising edge where valid and ready are both high;
// a source holds valid/data stable until that edge, and ready never depends on valid.
module cmpgt_argmax #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] max_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  count_q;
    logic             ovf_q;
    logic             mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             gt;

    assign accept    = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_ovf   = ovf_q;

    cmpgt #(.WIDTH(WIDTH)) u_cmpgt (
        .a         (in_data),
        .b         (max_q),
        .is_signed (mode_q),
        .gt        (gt)
    );

    // in_ready is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            max_q       <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        max_q   <= in_data;
                        idx_q   <= '0;
                        count_q <= IDXW'(1);
                        mode_q  <= is_signed;
                        ovf_q   <= 1'b0;
                        if (in_last) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // Strict compare: ties keep the earlier index.
                        if (gt) begin
                            max_q <= in_data;
                            idx_q <= count_q;
                        end
                        count_q <= count_q + IDXW'(1);
                        if (count_q == '1) begin
                            ovf_q <= 1'b1;
                        end
                        if (in_last) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmpgt_argmax.sv
// Self-checking bench for cmpgt_argmax: directed frames plus randomized frames
// scored against a frame-level argmax model.

module tb_cmpgt_argmax;

    localparam int WIDTH = 16;
    localparam int IDXW  = 2;
    localparam int NIDX  = 1 << IDXW;

    logic             clk;
    logic             rst_n;
    logic             is_signed;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IDXW-1:0]  out_idx;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    logic [WIDTH+IDXW:0] exp_q[$];
    logic [WIDTH-1:0]    frm[$];

    bit                  stall_prev = 0;
    bit                  ready_chk  = 0;
    logic [WIDTH-1:0]    held_max;
    logic [IDXW-1:0]     held_idx;
    logic                held_ovf;

    cmpgt_argmax #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .is_signed (is_signed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_ovf   (out_ovf)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: first position of the strict maximum under the frame's ordering
    function automatic int to_val(input logic [WIDTH-1:0] v, input bit s);
        if (s) return int'($signed(v));
        return int'(v);
    endfunction

    function automatic logic [WIDTH+IDXW:0] model(input bit s);
        int best = 0;
        for (int i = 1; i < frm.size(); i++) begin
            if (to_val(frm[i], s) > to_val(frm[best], s)) best = i;
        end
        return {frm[best], IDXW'(best % NIDX), frm.size() >= NIDX};
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // drivers: called and return at a negedge
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, input bit sgn);
        int guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        is_signed = sgn;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom();
        if (last) check("last_latency", out_valid, 1);
    endtask

    task automatic send_frame(input bit sgn, input int gap_pct, input bit toggle);
        exp_q.push_back(model(sgn));
        for (int i = 0; i < frm.size(); i++) begin
            bit s = (i > 0 && toggle) ? 1'($urandom_range(0, 1)) : sgn;
            while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
            send_beat(frm[i], i == frm.size() - 1, s);
        end
    endtask

    task automatic drain;
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (ready_chk) begin
                check("ready_after_hs", in_ready, 1);
                ready_chk = 0;
            end
            if (out_valid) begin
                if (stall_prev) begin
                    check("stall_max", out_max, held_max);
                    check("stall_idx", out_idx, held_idx);
                    check("stall_ovf", out_ovf, held_ovf);
                    check("stall_in_ready", in_ready, 0);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        logic [WIDTH+IDXW:0] e;
                        e = exp_q.pop_front();
                        check("out_max", out_max, e[WIDTH+IDXW:IDXW+1]);
                        check("out_idx", out_idx, e[IDXW:1]);
                        check("out_ovf", out_ovf, e[0]);
                    end
                    stall_prev = 0;
                    ready_chk  = 1;
                end else begin
                    stall_prev = 1;
                    held_max   = out_max;
                    held_idx   = out_idx;
                    held_ovf   = out_ovf;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        is_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max", out_max, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        frm = '{16'd3, 16'hFFFF, 16'd1};   send_frame(0, 0, 0);
        frm = '{16'd3, 16'hFFFF, 16'd1};   send_frame(1, 0, 0);
        frm = '{16'hFFFE, 16'hFFFF};       send_frame(1, 0, 0);
        frm = '{16'd5, 16'd7, 16'd7, 16'd2}; send_frame(0, 0, 0);
        frm = '{16'h8000};                 send_frame(1, 0, 0);
        drain();

        // backpressure with input bubbles, then a 4-cycle output stall
        ready_mode = 2;
        frm = '{16'd9, 16'd40, 16'd12, 16'd40, 16'd3};
        send_frame(0, 50, 0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("stall_wait", out_valid, 1);
        repeat (4) @(negedge clk);
        ready_mode = 0;
        drain();
        frm = '{16'd100, 16'd200}; send_frame(0, 0, 0);

        // index counter wrap
        frm = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd0}; send_frame(0, 0, 0);
        frm = '{16'd2, 16'd1};                             send_frame(0, 0, 0);
        drain();

        // reset mid-frame discards the partial frame
        send_beat(16'd10, 0, 0);
        send_beat(16'd20, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frm = '{16'd4, 16'd6}; send_frame(0, 0, 1);
        drain();

        // randomized frames
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            do n = $urandom_range(1, 10); while (n == NIDX);
            frm = {};
            for (int i = 0; i < n; i++) begin
                logic [WIDTH-1:0] v;
                case ($urandom_range(0, 3))
                    0:       v = 16'h8000;
                    1:       v = 16'($urandom_range(0, 7));
                    2:       v = 16'hFFFF - 16'($urandom_range(0, 3));
                    default: v = 16'($urandom());
                endcase
                frm.push_back(v);
            end
            send_frame(1'($urandom_range(0, 1)), 30, 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
